// File: rtl/axi_lite_reg_checker_if.sv
// AXI4-Lite bus bundle between the register checker (master) and the slave it exercises.
interface axi_lite_reg_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_checker.sv
// AXI4-Lite master that writes then reads back each slave register and reports
// the first bad response, data mismatch or handshake timeout.
module axi_lite_reg_checker #(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int                    C_NUM_REGS   = 4,
  parameter int                    C_TIMEOUT    = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [C_NUM_REGS*32-1:0] test_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [3:0]               err_index,
  output logic [1:0]               err_code,
  axi_lite_reg_checker_if.master   m_axi
);

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam int TW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, CHECK, FINISH} state_t;

  state_t                          state, state_n;
  logic [3:0]                      idx, idx_n;
  logic                            aw_pend, aw_n, w_pend, w_n;
  logic [TW-1:0]                   tmo, tmo_n;
  logic                            tmo_hit, ld, drain_en;
  logic                            pass_n;
  logic [3:0]                      eidx_n;
  logic [1:0]                      ecode_n;
  logic [C_NUM_REGS-1:0][31:0]     shadow;
  logic [C_DATA_WIDTH-1:0]         rdata_q;
  logic [1:0]                      rresp_q;
  logic [31:0]                     cur_word;
  logic [C_ADDR_WIDTH-1:0]         cur_addr;

  assign cur_word = shadow[idx[IW-1:0]];
  assign cur_addr = C_BASE_ADDR + (C_ADDR_WIDTH'(idx) << 2);
  assign tmo_hit  = (tmo == TW'(C_TIMEOUT - 1));

  assign busy = (state != IDLE) && (state != FINISH);
  assign done = (state == FINISH);

  assign m_axi.awaddr  = busy ? cur_addr : '0;
  assign m_axi.araddr  = busy ? cur_addr : '0;
  assign m_axi.wdata   = busy ? C_DATA_WIDTH'(cur_word) : '0;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wstrb   = '1;
  assign m_axi.awvalid = aw_pend;
  assign m_axi.wvalid  = w_pend;
  assign m_axi.arvalid = (state == RADDR);
  // Late responses from an aborted access are swallowed while not running.
  assign m_axi.bready  = (state == WRESP) || (drain_en && !busy);
  assign m_axi.rready  = (state == RDATA) || (drain_en && !busy);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      idx       <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      tmo       <= '0;
      shadow    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pass      <= 1'b0;
      err_index <= '0;
      err_code  <= '0;
      drain_en  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      aw_pend   <= aw_n;
      w_pend    <= w_n;
      tmo       <= tmo_n;
      pass      <= pass_n;
      err_index <= eidx_n;
      err_code  <= ecode_n;
      drain_en  <= 1'b1;
      if (ld) shadow <= test_data;
      if (state == RDATA && m_axi.rvalid) begin
        rdata_q <= m_axi.rdata;
        rresp_q <= m_axi.rresp;
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    aw_n    = aw_pend;
    w_n     = w_pend;
    tmo_n   = '0;
    pass_n  = pass;
    eidx_n  = err_index;
    ecode_n = err_code;
    ld      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = WRITE;
        idx_n   = '0;
        aw_n    = 1'b1;
        w_n     = 1'b1;
        pass_n  = 1'b0;
        eidx_n  = '0;
        ecode_n = 2'd0;
        ld      = 1'b1;
      end
      WRITE: begin
        // Each channel retires on its own handshake; both must finish to move on.
        aw_n = aw_pend && !m_axi.awready;
        w_n  = w_pend && !m_axi.wready;
        if (!aw_n && !w_n) state_n = WRESP;
        else if (tmo_hit) begin
          aw_n = 1'b0; w_n = 1'b0;
          eidx_n = idx; ecode_n = 2'd3; state_n = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      WRESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            eidx_n = idx; ecode_n = 2'd1; state_n = FINISH;
          end else state_n = RADDR;
        end else if (tmo_hit) begin
          eidx_n = idx; ecode_n = 2'd3; state_n = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      RADDR: begin
        if (m_axi.arready) state_n = RDATA;
        else if (tmo_hit) begin
          eidx_n = idx; ecode_n = 2'd3; state_n = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      RDATA: begin
        if (m_axi.rvalid) state_n = CHECK;
        else if (tmo_hit) begin
          eidx_n = idx; ecode_n = 2'd3; state_n = FINISH;
        end else tmo_n = tmo + 1'b1;
      end
      CHECK: begin
        if (rresp_q != 2'b00) begin
          eidx_n = idx; ecode_n = 2'd1; state_n = FINISH;
        end else if (rdata_q != C_DATA_WIDTH'(cur_word)) begin
          eidx_n = idx; ecode_n = 2'd2; state_n = FINISH;
        end else if (idx == 4'(C_NUM_REGS - 1)) begin
          pass_n = 1'b1; state_n = FINISH;
        end else begin
          idx_n = idx + 1'b1; aw_n = 1'b1; w_n = 1'b1; state_n = WRITE;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_reg_checker.sv
// Directed bench: behavioural AXI4-Lite slave with injectable stalls, bad
// responses and corrupted reads, checked against hand-computed results.
module tb_axi_lite_reg_checker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] test_data = '0;
  logic         busy, done, pass;
  logic [3:0]   err_index;
  logic [1:0]   err_code;

  int checks = 0;
  int errors = 0;

  axi_lite_reg_checker_if bus ();

  axi_lite_reg_checker dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .start     (start),
    .test_data (test_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_index (err_index),
    .err_code  (err_code),
    .m_axi     (bus)
  );

  always #5 clk = ~clk;

  // slave model knobs
  int aw_dly = 0, w_dly = 0, bad_b_idx = -1, bad_r_idx = -1;
  bit ar_hang = 1'b0;

  int          aw_wait, w_wait, aw_hs_n, w_hs_n;
  int          wr_n [16];
  int          rd_n [16];
  logic [31:0] mem  [16];
  logic        got_aw, got_w;
  logic [31:0] sa, sd;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_dly);
  assign bus.wready  = bus.wvalid && (w_wait >= w_dly);
  assign bus.arready = bus.arvalid && !ar_hang;

  wire        aw_hs = bus.awvalid && bus.awready;
  wire        w_hs  = bus.wvalid && bus.wready;
  wire        ar_hs = bus.arvalid && bus.arready;
  wire [31:0] wa    = aw_hs ? bus.awaddr : sa;
  wire [31:0] wd    = w_hs ? bus.wdata : sd;
  wire        wr_go = (got_aw || aw_hs) && (got_w || w_hs);

  always @(posedge clk) begin
    if (rst) begin
      got_aw <= 1'b0; got_w <= 1'b0; sa <= '0; sd <= '0;
      aw_wait <= 0; w_wait <= 0; aw_hs_n <= 0; w_hs_n <= 0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0; wr_n[i] <= 0; rd_n[i] <= 0;
      end
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
      if (aw_hs) begin sa <= bus.awaddr; got_aw <= 1'b1; aw_hs_n <= aw_hs_n + 1; end
      if (w_hs)  begin sd <= bus.wdata;  got_w  <= 1'b1; w_hs_n  <= w_hs_n + 1;  end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (wr_go) begin
        mem[wa[5:2]]  <= wd;
        wr_n[wa[5:2]] <= wr_n[wa[5:2]] + 1;
        bus.bvalid    <= 1'b1;
        bus.bresp     <= (int'(wa[5:2]) == bad_b_idx) ? 2'b10 : 2'b00;
        got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (ar_hs) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= 2'b00;
        bus.rdata  <= (int'(bus.araddr[5:2]) == bad_r_idx) ? 32'hABCD0000 : mem[bus.araddr[5:2]];
        rd_n[bus.araddr[5:2]] <= rd_n[bus.araddr[5:2]] + 1;
      end
    end
  end

  int wr0 [16];
  int rd0 [16];
  int aw0, w0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 16; i++) begin wr0[i] = wr_n[i]; rd0[i] = rd_n[i]; end
    aw0 = aw_hs_n; w0 = w_hs_n;
  endtask

  // start pulse, then count cycles until done; cyc=1 is the cycle after the start edge
  task automatic run(input logic [127:0] data, input bit mid_start, output int cyc);
    snap();
    test_data = data;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1'b1);
    while (!done && cyc < 1000) begin
      if (mid_start && cyc == 5) begin start = 1'b1; test_data = ~data; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) chk("done_seen", done, 1'b1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  localparam logic [127:0] D1 = 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF;
  localparam logic [127:0] D2 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] D3 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    int cyc;
    bit saw_done;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_index", err_index, 4'd0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
    chk("rst_readys", {bus.bready, bus.rready}, 2'b00);
    chk("rst_awaddr", bus.awaddr, 32'h0);
    chk("rst_araddr", bus.araddr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_drain_readys", {bus.bready, bus.rready}, 2'b11);
    chk("prot_strb", {bus.awprot, bus.arprot, bus.wstrb}, {6'b0, 4'hF});

    // zero-wait slave
    run(D1, 1'b0, cyc);
    chk("t1_cycles", cyc, 21);
    chk("t1_pass", pass, 1'b1);
    chk("t1_code", err_code, 2'd0);
    chk("t1_index", err_index, 4'd0);
    chk("t1_mem0", mem[0], 32'h0101FFFF);
    chk("t1_mem1", mem[1], 32'hABCD0001);
    chk("t1_mem2", mem[2], 32'hDEAD0011);
    chk("t1_mem3", mem[3], 32'hBEEF0011);
    for (int i = 0; i < 4; i++) begin
      chk("t1_writes", wr_n[i] - wr0[i], 1);
      chk("t1_reads", rd_n[i] - rd0[i], 1);
    end
    after_done();

    // WREADY lags AWREADY by 3 cycles; a start while busy must be ignored
    w_dly = 3;
    run(D2, 1'b1, cyc);
    chk("t2_cycles", cyc, 33);
    chk("t2_pass", pass, 1'b1);
    chk("t2_aw_count", aw_hs_n - aw0, 4);
    chk("t2_w_count", w_hs_n - w0, 4);
    chk("t2_mem0", mem[0], 32'h1);
    chk("t2_mem3", mem[3], 32'h4);
    w_dly = 0;
    after_done();

    // bad write response on register 2
    bad_b_idx = 2;
    run(D1, 1'b0, cyc);
    chk("t3_cycles", cyc, 13);
    chk("t3_pass", pass, 1'b0);
    chk("t3_index", err_index, 4'd2);
    chk("t3_code", err_code, 2'd1);
    chk("t3_no_read2", rd_n[2] - rd0[2], 0);
    chk("t3_no_write3", wr_n[3] - wr0[3], 0);
    bad_b_idx = -1;
    after_done();

    // corrupted readback on register 1
    bad_r_idx = 1;
    run(D1, 1'b0, cyc);
    chk("t4_cycles", cyc, 11);
    chk("t4_pass", pass, 1'b0);
    chk("t4_index", err_index, 4'd1);
    chk("t4_code", err_code, 2'd2);
    chk("t4_no_write2", wr_n[2] - wr0[2], 0);
    chk("t4_no_read2", rd_n[2] - rd0[2], 0);
    bad_r_idx = -1;
    after_done();

    // ARREADY never comes: 256 wait cycles in RADDR then abort
    ar_hang = 1'b1;
    run(D1, 1'b0, cyc);
    chk("t5_cycles", cyc, 259);
    chk("t5_code", err_code, 2'd3);
    chk("t5_index", err_index, 4'd0);
    chk("t5_pass", pass, 1'b0);
    chk("t5_arvalid", bus.arvalid, 1'b0);
    ar_hang = 1'b0;
    after_done();
    chk("t5_arvalid_idle", bus.arvalid, 1'b0);
    run(D2, 1'b0, cyc);
    chk("t5_recover_cycles", cyc, 21);
    chk("t5_recover_pass", pass, 1'b1);
    chk("t5_recover_code", err_code, 2'd0);
    after_done();

    // reset while reading back register 3
    test_data = D1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (18) @(negedge clk);
    chk("t6_in_rdata3", {bus.rready, bus.araddr}, {1'b1, 32'hC});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_pass", pass, 1'b0);
    chk("t6_rst_err", {err_index, err_code}, 6'd0);
    chk("t6_rst_bus", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t6_no_stale_done", saw_done, 1'b0);
    run(D3, 1'b0, cyc);
    chk("t6_fresh_cycles", cyc, 21);
    chk("t6_fresh_pass", pass, 1'b1);
    chk("t6_fresh_mem2", mem[2], 32'h33333333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
